// File: rtl/ls193_sync_if.sv
// Pin bundle of one LS193 counter stage: count pulses, clear, preset and outputs.
// Latency: none (wiring only). Backpressure: none, the counter accepts inputs every cycle.
interface ls193_sync_if #(
    parameter int WIDTH = 4
);
    logic             UP;
    logic             DOWN;
    logic             CLR;
    logic             _LOAD;
    logic [WIDTH-1:0] D;
    logic [WIDTH-1:0] Q;
    logic             _CO;
    logic             _BO;

    modport master (
        output UP, DOWN, CLR, _LOAD, D,
        input  Q, _CO, _BO
    );

    modport slave (
        input  UP, DOWN, CLR, _LOAD, D,
        output Q, _CO, _BO
    );
endinterface

// File: rtl/ls193_sync.sv
// Synchronous LS193 up/down counter; UP/DOWN pulses are edge-detected on clk.
// Latency: Q updates 1 clk after a sampled edge. Backpressure: none; pulses shorter than 1 clk are lost.
module ls193_sync #(
    parameter int WIDTH = 4
) (
    input  logic         clk,
    input  logic         rst,
    ls193_sync_if.slave  bus
);
    localparam logic [WIDTH-1:0] QMAX = {WIDTH{1'b1}};

    logic [WIDTH-1:0] q_q, q_d;
    logic             up_q, dn_q;
    logic             up_rise, dn_rise;

    // Edge history resets high so levels held high through reset do not count.
    always_ff @(posedge clk) begin
        if (rst) begin
            q_q  <= '0;
            up_q <= 1'b1;
            dn_q <= 1'b1;
        end else begin
            q_q  <= q_d;
            up_q <= bus.UP;
            dn_q <= bus.DOWN;
        end
    end

    assign up_rise = bus.UP & ~up_q;
    assign dn_rise = bus.DOWN & ~dn_q;

    always_comb begin
        q_d = q_q;
        if (bus.CLR) begin
            q_d = '0;
        end else if (!bus._LOAD) begin
            q_d = bus.D;
        end else if (up_rise && !dn_rise && bus.DOWN) begin
            q_d = q_q + 1'b1;
        end else if (dn_rise && !up_rise && bus.UP) begin
            q_d = q_q - 1'b1;
        end
    end

    // Carry/borrow follow the live pulse level so a cascaded stage sees a rising edge on wrap.
    assign bus.Q   = q_q;
    assign bus._CO = ~((q_q == QMAX) & ~bus.UP);
    assign bus._BO = ~((q_q == '0) & ~bus.DOWN);
endmodule

// File: tb/tb_ls193_sync.sv
module tb_ls193_sync;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    ls193_sync_if #(.WIDTH(4)) bus ();
    ls193_sync_if #(.WIDTH(4)) ifl ();
    ls193_sync_if #(.WIDTH(4)) ifh ();

    ls193_sync #(.WIDTH(4)) dut  (.clk(clk), .rst(rst), .bus(bus.slave));
    ls193_sync #(.WIDTH(4)) u_lo (.clk(clk), .rst(rst), .bus(ifl.slave));
    ls193_sync #(.WIDTH(4)) u_hi (.clk(clk), .rst(rst), .bus(ifh.slave));

    assign ifh.UP   = ifl._CO;
    assign ifh.DOWN = ifl._BO;

    typedef struct {
        string      tag;
        logic       r, up, dn, clr, ld_n;
        logic [3:0] d;
        logic [3:0] q;
        logic       co, bo;
    } vec_t;

    typedef struct {
        string      tag;
        logic [3:0] q;
        logic       co, bo;
    } exp_t;

    typedef struct {
        string      tag;
        logic [7:0] val;
    } cexp_t;

    exp_t  sb[$];
    cexp_t csb[$];
    int    n_chk  = 0;
    int    n_fail = 0;

    task automatic apply(input vec_t v);
        exp_t e;
        rst       = v.r;
        bus.UP    = v.up;
        bus.DOWN  = v.dn;
        bus.CLR   = v.clr;
        bus._LOAD = v.ld_n;
        bus.D     = v.d;
        e.tag = v.tag; e.q = v.q; e.co = v.co; e.bo = v.bo;
        sb.push_back(e);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        n_chk++;
        if ({bus.Q, bus._CO, bus._BO} !== {e.q, e.co, e.bo}) begin
            n_fail++;
            $display("FAIL %s: got Q=%h _CO=%b _BO=%b, want Q=%h _CO=%b _BO=%b",
                     e.tag, bus.Q, bus._CO, bus._BO, e.q, e.co, e.bo);
        end
    endtask

    task automatic step(input string tag, input logic up, input logic dn,
                        input logic clr, input logic ld_n, input logic [3:0] d,
                        input logic [3:0] q, input logic co, input logic bo);
        vec_t v;
        v.tag = tag; v.r = 1'b0; v.up = up; v.dn = dn; v.clr = clr; v.ld_n = ld_n;
        v.d = d; v.q = q; v.co = co; v.bo = bo;
        apply(v);
    endtask

    // One cascade clock; when chk is set the 8-bit count is scoreboarded for this edge.
    task automatic ccyc(input string tag, input logic up, input logic dn, input logic ld_n,
                        input logic [7:0] d, input bit chk, input logic [7:0] expv);
        cexp_t c;
        ifl.UP    = up;
        ifl.DOWN  = dn;
        ifl._LOAD = ld_n;
        ifh._LOAD = ld_n;
        ifl.D     = d[3:0];
        ifh.D     = d[7:4];
        if (chk) begin
            c.tag = tag; c.val = expv;
            csb.push_back(c);
        end
        @(posedge clk);
        #1;
        if (chk) begin
            c = csb.pop_front();
            n_chk++;
            if ({ifh.Q, ifl.Q} !== c.val) begin
                n_fail++;
                $display("FAIL %s: got count=%h, want %h", c.tag, {ifh.Q, ifl.Q}, c.val);
            end
        end
    endtask

    vec_t vecs[$];
    int   cur;

    initial begin
        ifl.UP = 1'b1; ifl.DOWN = 1'b1; ifl.CLR = 1'b0; ifl._LOAD = 1'b1; ifl.D = 4'h0;
        ifh.CLR = 1'b0; ifh._LOAD = 1'b1; ifh.D = 4'h0;

        //          tag           r   up  dn  clr ld_n d      q      co  bo
        vecs.push_back('{"rst0",     1, 1, 1, 0, 1, 4'h0, 4'h0, 1, 1});
        vecs.push_back('{"rst1",     1, 1, 1, 0, 1, 4'h0, 4'h0, 1, 1});
        vecs.push_back('{"post_rst", 0, 1, 1, 0, 1, 4'h0, 4'h0, 1, 1});
        vecs.push_back('{"load2",    0, 1, 1, 0, 0, 4'h2, 4'h2, 1, 1});
        vecs.push_back('{"hold2",    0, 1, 1, 0, 1, 4'h5, 4'h2, 1, 1});
        vecs.push_back('{"dn_lo2",   0, 1, 0, 0, 1, 4'h0, 4'h2, 1, 1});
        vecs.push_back('{"dn_to1",   0, 1, 1, 0, 1, 4'h0, 4'h1, 1, 1});
        vecs.push_back('{"dn_lo1",   0, 1, 0, 0, 1, 4'h0, 4'h1, 1, 1});
        vecs.push_back('{"dn_to0",   0, 1, 1, 0, 1, 4'h0, 4'h0, 1, 1});
        vecs.push_back('{"bo_low",   0, 1, 0, 0, 1, 4'h0, 4'h0, 1, 0});
        vecs.push_back('{"dn_wrap",  0, 1, 1, 0, 1, 4'h0, 4'hF, 1, 1});
        vecs.push_back('{"dn_lo15",  0, 1, 0, 0, 1, 4'h0, 4'hF, 1, 1});
        vecs.push_back('{"dn_to14",  0, 1, 1, 0, 1, 4'h0, 4'hE, 1, 1});
        vecs.push_back('{"up_lo14",  0, 0, 1, 0, 1, 4'h0, 4'hE, 1, 1});
        vecs.push_back('{"clr_prio", 0, 1, 1, 1, 0, 4'h9, 4'h0, 1, 1});
        vecs.push_back('{"load9",    0, 1, 1, 0, 0, 4'h9, 4'h9, 1, 1});
        vecs.push_back('{"ld_uplo",  0, 0, 1, 0, 0, 4'h9, 4'h9, 1, 1});
        vecs.push_back('{"ld_uprise",0, 1, 1, 0, 0, 4'h9, 4'h9, 1, 1});
        vecs.push_back('{"post_ld",  0, 1, 1, 0, 1, 4'h9, 4'h9, 1, 1});
        vecs.push_back('{"both_lo",  0, 0, 0, 0, 1, 4'h0, 4'h9, 1, 1});
        vecs.push_back('{"both_rise",0, 1, 1, 0, 1, 4'h0, 4'h9, 1, 1});
        vecs.push_back('{"both_lo2", 0, 0, 0, 0, 1, 4'h0, 4'h9, 1, 1});
        vecs.push_back('{"up_dnlow", 0, 1, 0, 0, 1, 4'h0, 4'h9, 1, 1});
        vecs.push_back('{"dn_legal", 0, 1, 1, 0, 1, 4'h0, 4'h8, 1, 1});
        vecs.push_back('{"up_lo8",   0, 0, 1, 0, 1, 4'h0, 4'h8, 1, 1});
        vecs.push_back('{"clr_uprs", 0, 1, 1, 1, 1, 4'h0, 4'h0, 1, 1});
        vecs.push_back('{"no_late",  0, 1, 1, 0, 1, 4'h0, 4'h0, 1, 1});

        foreach (vecs[i]) apply(vecs[i]);

        // 17 up pulses from 0, 4 clk low / 4 clk high, ending at 1 after a wrap.
        cur = 0;
        for (int p = 0; p < 17; p++) begin
            for (int k = 0; k < 4; k++)
                step("up_pulse_lo", 1'b0, 1'b1, 1'b0, 1'b1, 4'h0, 4'(cur),
                     (cur == 15) ? 1'b0 : 1'b1, 1'b1);
            cur = (cur + 1) % 16;
            for (int k = 0; k < 4; k++)
                step("up_pulse_hi", 1'b1, 1'b1, 1'b0, 1'b1, 4'h0, 4'(cur), 1'b1, 1'b1);
        end

        ccyc("casc_load", 1'b1, 1'b1, 1'b0, 8'h0E, 1'b1, 8'h0E);
        ccyc("casc_idle", 1'b1, 1'b1, 1'b1, 8'h00, 1'b1, 8'h0E);
        for (int p = 0; p < 3; p++) begin
            ccyc("casc_up_lo", 1'b0, 1'b1, 1'b1, 8'h00, 1'b0, 8'h00);
            ccyc("casc_up_lo", 1'b0, 1'b1, 1'b1, 8'h00, 1'b0, 8'h00);
            ccyc("casc_up_hi", 1'b1, 1'b1, 1'b1, 8'h00, 1'b0, 8'h00);
            ccyc("casc_up",    1'b1, 1'b1, 1'b1, 8'h00, 1'b1, 8'(8'h0F + p));
        end
        for (int p = 0; p < 2; p++) begin
            ccyc("casc_dn_lo", 1'b1, 1'b0, 1'b1, 8'h00, 1'b0, 8'h00);
            ccyc("casc_dn_lo", 1'b1, 1'b0, 1'b1, 8'h00, 1'b0, 8'h00);
            ccyc("casc_dn_hi", 1'b1, 1'b1, 1'b1, 8'h00, 1'b0, 8'h00);
            ccyc("casc_dn",    1'b1, 1'b1, 1'b1, 8'h00, 1'b1, 8'(8'h10 - p));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
